vec_op_arbiter: RTL and testbench

- Shares one in-order fifo_math vector unit (e.g. sub, ARRAY_SIZE lanes) between two FIFO-style requesters, A and B.
- Forward path: round-robin selection of operand pairs.
- Return path: a tag FIFO records which requester each pop belongs to, and results are steered back to that requester's output interface.
- Sits between the per-requester operand fifo_arrays and the shared unit's in_empty/in_rd_en and out_empty/out_rd_en ports.

---
 rtl/vec_op_arbiter.sv | 117 +++++++++++
 tb/tb_vec_op_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vec_op_arbiter
// Brief    : Round-robin sharing of one in-order vector unit between two
//            FIFO-style requesters; a tag FIFO steers results back.
// Revision : 1.0
// ============================================================================
module vec_op_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_x,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_y,
    input  logic                                  a_empty,
    output logic                                  a_rd_en,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_x,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_y,
    input  logic                                  b_empty,
    output logic                                  b_rd_en,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] op_x,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] op_y,
    output logic                                  op_empty,
    input  logic                                  op_rd_en,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] res,
    input  logic                                  res_empty,
    output logic                                  res_rd_en,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] a_out,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] b_out,
    output logic                                  a_out_empty,
    output logic                                  b_out_empty,
    input  logic                                  a_out_rd_en,
    input  logic                                  b_out_rd_en,
    output logic [$clog2(TAG_DEPTH):0]            inflight
);

    localparam int                 c_PTR_W = $clog2(TAG_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(TAG_DEPTH);

    logic                 r_grant;
    logic [TAG_DEPTH-1:0] r_tags;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [1:0]           w_src_empty;
    logic                 w_other;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;
    logic                 w_grant_next;

    assign w_src_empty = {b_empty, a_empty};
    assign w_other     = ~r_grant;
    assign w_tag_full  = (r_count == c_FULL);
    assign w_tag_empty = (r_count == '0);
    assign w_head      = r_tags[r_rd_ptr];

    // Forward path: pure mux on the registered grant
    assign op_x     = r_grant ? b_x : a_x;
    assign op_y     = r_grant ? b_y : a_y;
    assign op_empty = w_src_empty[r_grant] || w_tag_full;
    assign w_push   = op_rd_en && !op_empty;
    assign a_rd_en  = w_push && !r_grant;
    assign b_rd_en  = w_push && r_grant;

    // Return path: the head tag decides which consumer may see the result
    assign a_out       = res;
    assign b_out       = res;
    assign a_out_empty = res_empty || w_tag_empty || w_head;
    assign b_out_empty = res_empty || w_tag_empty || !w_head;
    assign w_pop       = (a_out_rd_en && !a_out_empty) || (b_out_rd_en && !b_out_empty);
    assign res_rd_en   = w_pop;
    assign inflight    = r_count;

    always_comb begin
        w_grant_next = r_grant;
        if (w_push) begin
            if (!w_src_empty[w_other]) begin
                w_grant_next = w_other;
            end
        end else if (w_src_empty[r_grant] && !w_src_empty[w_other]) begin
            w_grant_next = w_other;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_grant  <= 1'b0;
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_grant <= w_grant_next;
            if (w_push) begin
                r_tags[r_wr_ptr] <= r_grant;
                r_wr_ptr         <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_op_arbiter
// Brief    : Directed scoreboard bench for vec_op_arbiter with FIFO and
//            in-order subtract-unit models around it.
// Revision : 1.0
// ============================================================================
module tb_vec_op_arbiter;

    localparam int DW = 32;
    localparam int AS = 3;
    localparam int TD = 16;
    localparam int CW = $clog2(TD) + 1;

    typedef logic [AS-1:0][DW-1:0] vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    vec_t          a_x = '0, a_y = '0, b_x = '0, b_y = '0, res = '0;
    logic          a_empty = 1'b1, b_empty = 1'b1, res_empty = 1'b1;
    logic          op_rd_en = 1'b0, a_out_rd_en = 1'b0, b_out_rd_en = 1'b0;
    vec_t          op_x, op_y, a_out, b_out;
    logic          a_rd_en, b_rd_en, op_empty, res_rd_en, a_out_empty, b_out_empty;
    logic [CW-1:0] inflight;

    vec_op_arbiter #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .TAG_DEPTH(TD)) dut (
        .clock(clock), .reset(reset),
        .a_x(a_x), .a_y(a_y), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_x(b_x), .b_y(b_y), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .op_x(op_x), .op_y(op_y), .op_empty(op_empty), .op_rd_en(op_rd_en),
        .res(res), .res_empty(res_empty), .res_rd_en(res_rd_en),
        .a_out(a_out), .b_out(b_out),
        .a_out_empty(a_out_empty), .b_out_empty(b_out_empty),
        .a_out_rd_en(a_out_rd_en), .b_out_rd_en(b_out_rd_en),
        .inflight(inflight)
    );

    always #5 clock = ~clock;

    vec_t ax_q[$], ay_q[$], bx_q[$], by_q[$], unit_q[$];
    vec_t exp_a[$], exp_b[$];
    logic deliv[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_del_a  = 0;
    int   n_del_b  = 0;
    int   cyc      = 0;
    int   a_first  = -1;
    int   a_last   = -1;

    logic s_a_pop = 1'b0, s_b_pop = 1'b0, s_op_pop = 1'b0, s_res_pop = 1'b0;
    vec_t s_op_x = '0, s_op_y = '0;

    task automatic drive_env();
        a_empty   = (ax_q.size() == 0);
        a_x       = a_empty ? '0 : ax_q[0];
        a_y       = a_empty ? '0 : ay_q[0];
        b_empty   = (bx_q.size() == 0);
        b_x       = b_empty ? '0 : bx_q[0];
        b_y       = b_empty ? '0 : by_q[0];
        res_empty = (unit_q.size() == 0);
        res       = res_empty ? '0 : unit_q[0];
    endtask

    // Operand FIFOs and the in-order subtract unit share the arbiter's reset
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            ax_q.delete(); ay_q.delete(); bx_q.delete(); by_q.delete();
            unit_q.delete();
            drive_env();
        end else begin
            vec_t r;
            #1;
            if (s_a_pop && ax_q.size() > 0) begin
                void'(ax_q.pop_front()); void'(ay_q.pop_front());
            end
            if (s_b_pop && bx_q.size() > 0) begin
                void'(bx_q.pop_front()); void'(by_q.pop_front());
            end
            if (s_res_pop && unit_q.size() > 0) void'(unit_q.pop_front());
            if (s_op_pop) begin
                for (int i = 0; i < AS; i++) r[i] = s_op_x[i] - s_op_y[i];
                unit_q.push_back(r);
            end
            drive_env();
        end
    end

    // Handshake sampler: captures what the DUT will act on at the next edge
    initial forever begin
        @(negedge clock);
        cyc++;
        if (reset) begin
            s_a_pop = 1'b0; s_b_pop = 1'b0; s_op_pop = 1'b0; s_res_pop = 1'b0;
        end else begin
            s_a_pop   = a_rd_en;
            s_b_pop   = b_rd_en;
            s_op_pop  = op_rd_en && !op_empty;
            s_op_x    = op_x;
            s_op_y    = op_y;
            s_res_pop = res_rd_en;
            if (a_rd_en) begin
                if (a_first < 0) a_first = cyc;
                a_last = cyc;
            end
        end
    end

    // Scoreboard monitor
    initial forever begin
        vec_t e;
        @(negedge clock);
        if (!reset) begin
            if (a_out_rd_en && !a_out_empty) begin
                deliv.push_back(1'b0);
                n_del_a++;
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_out_unexpected: got %h, required no result", a_out);
                end else begin
                    e = exp_a.pop_front();
                    if (a_out !== e) begin
                        n_fail++;
                        $display("FAIL a_out_data: got %h, required %h", a_out, e);
                    end
                end
            end
            if (b_out_rd_en && !b_out_empty) begin
                deliv.push_back(1'b1);
                n_del_b++;
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_out_unexpected: got %h, required no result", b_out);
                end else begin
                    e = exp_b.pop_front();
                    if (b_out !== e) begin
                        n_fail++;
                        $display("FAIL b_out_data: got %h, required %h", b_out, e);
                    end
                end
            end
            n_checks++;
            if (!res_empty && inflight == '0) begin
                n_fail++;
                $display("FAIL protocol_res_without_tag: res_empty=%b inflight=%0d, required no result with no tag",
                         res_empty, inflight);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_a(input vec_t x, input vec_t y, input vec_t e);
        ax_q.push_back(x); ay_q.push_back(y); exp_a.push_back(e);
    endtask

    task automatic push_b(input vec_t x, input vec_t y, input vec_t e);
        bx_q.push_back(x); by_q.push_back(y); exp_b.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((ax_q.size() + bx_q.size() + unit_q.size() + exp_a.size() + exp_b.size()) != 0
               || inflight != '0) begin
            if (n >= max_cycles) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_timeout: got %0d results outstanding, required 0",
                         name, exp_a.size() + exp_b.size());
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_inflight"},    128'(inflight),    128'(0));
        chk({tag, "_op_empty"},    128'(op_empty),    128'(1));
        chk({tag, "_a_out_empty"}, 128'(a_out_empty), 128'(1));
        chk({tag, "_b_out_empty"}, 128'(b_out_empty), 128'(1));
        chk({tag, "_a_rd_en"},     128'(a_rd_en),     128'(0));
        chk({tag, "_b_rd_en"},     128'(b_rd_en),     128'(0));
        chk({tag, "_res_rd_en"},   128'(res_rd_en),   128'(0));
    endtask

    initial begin
        int   da, db;
        logic [7:0] order;
        vec_t vx, vy, ve;

        // Reset state
        @(negedge clock);
        chk_idle_outputs("reset");
        tick();
        reset = 1'b0;

        // Idle switch: g=0, A empty, B becomes non-empty
        vx = {32'h0, 32'h0, 32'h0005_0000};
        vy = {32'h0, 32'h0, 32'h0001_0000};
        push_b(vx, vy, {32'h0, 32'h0, 32'h0004_0000});
        tick();
        @(negedge clock);
        chk("idle_switch_bubble_op_empty", 128'(op_empty), 128'(1));
        tick();
        @(negedge clock);
        chk("idle_switch_op_empty", 128'(op_empty), 128'(0));
        chk("idle_switch_op_x", 128'(op_x), 128'(vx));
        tick();
        op_rd_en    = 1'b1;
        b_out_rd_en = 1'b1;
        wait_drain("idle_switch", 50);

        // A-only stream of 8 identical subtractions 3.0 - 1.0
        a_out_rd_en = 1'b1;
        a_first = -1;
        da = n_del_a;
        db = n_del_b;
        for (int k = 0; k < 8; k++)
            push_a({3{32'h0003_0000}}, {3{32'h0001_0000}}, {3{32'h0002_0000}});
        wait_drain("a_only", 100);
        chk("a_only_count", 128'(n_del_a - da), 128'(8));
        chk("a_only_no_b", 128'(n_del_b - db), 128'(0));
        chk("a_only_rate", 128'(a_last - a_first), 128'(7));

        // Alternation with distinct per-requester values
        deliv.delete();
        da = n_del_a;
        db = n_del_b;
        for (int k = 1; k <= 4; k++) begin
            push_a({32'h0, 32'(k), 32'((k + 5) << 16)},
                   {32'(k), 32'h0, 32'h0005_0000},
                   {32'(-k), 32'(k), 32'(k << 16)});
            push_b({32'h1234_5678, 32'hFFFF_0000, 32'(32'h1000 + k * 32'h100)},
                   {32'h1234_5678, 32'h0001_0000, 32'h0000_1000},
                   {32'h0, 32'hFFFE_0000, 32'(k * 32'h100)});
        end
        wait_drain("alternate", 100);
        order = '0;
        for (int i = 0; i < 8; i++) if (i < deliv.size()) order[i] = deliv[i];
        chk("alternate_deliveries", 128'(deliv.size()), 128'(8));
        chk("alternate_tag_order", 128'(order), 128'(8'hAA));
        chk("alternate_count_a", 128'(n_del_a - da), 128'(4));
        chk("alternate_count_b", 128'(n_del_b - db), 128'(4));

        // Back-pressure: consumers stalled, 20 ops offered on A
        a_out_rd_en = 1'b0;
        b_out_rd_en = 1'b0;
        da = n_del_a;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < AS; j++) begin
                vx[j] = 32'((k + 1) << 16) + 32'(j);
                vy[j] = 32'h0000_8000;
                ve[j] = 32'((k + 1) << 16) + 32'(j) - 32'h0000_8000;
            end
            push_a(vx, vy, ve);
        end
        repeat (30) tick();
        @(negedge clock);
        chk("backpressure_inflight", 128'(inflight), 128'(TD));
        chk("backpressure_op_empty", 128'(op_empty), 128'(1));
        chk("backpressure_a_rd_en", 128'(a_rd_en), 128'(0));
        chk("backpressure_a_out_avail", 128'(a_out_empty), 128'(0));
        tick();
        a_out_rd_en = 1'b1;
        wait_drain("backpressure", 200);
        chk("backpressure_count", 128'(n_del_a - da), 128'(20));

        // Head-of-line: head tag A stalled while B's consumer is ready
        a_out_rd_en = 1'b0;
        b_out_rd_en = 1'b1;
        deliv.delete();
        push_a({3{32'h0000_0700}}, {3{32'h0000_0100}}, {3{32'h0000_0600}});
        push_b({3{32'h0009_0000}}, {3{32'h0002_0000}}, {3{32'h0007_0000}});
        repeat (6) tick();
        @(negedge clock);
        chk("hol_inflight", 128'(inflight), 128'(2));
        chk("hol_res_rd_en", 128'(res_rd_en), 128'(0));
        chk("hol_b_out_empty", 128'(b_out_empty), 128'(1));
        chk("hol_a_out_avail", 128'(a_out_empty), 128'(0));
        repeat (3) tick();
        @(negedge clock);
        chk("hol_b_still_blocked", 128'(b_out_empty), 128'(1));
        tick();
        a_out_rd_en = 1'b1;
        wait_drain("hol", 50);
        order = '0;
        for (int i = 0; i < 2; i++) if (i < deliv.size()) order[i] = deliv[i];
        chk("hol_order", 128'({deliv.size() == 2, order[1:0]}), 128'(3'b110));

        // Reset mid-stream with five B ops in flight (grant left on B)
        a_out_rd_en = 1'b0;
        b_out_rd_en = 1'b0;
        for (int k = 0; k < 5; k++)
            push_b({3{32'h0004_0000}}, {3{32'h0001_0000}}, {3{32'h0003_0000}});
        repeat (8) tick();
        @(negedge clock);
        chk("midreset_pre_inflight", 128'(inflight), 128'(5));
        tick();
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        #1;
        chk_idle_outputs("midreset");
        tick();
        reset = 1'b0;

        // Grant must restart on A after reset
        a_out_rd_en = 1'b1;
        b_out_rd_en = 1'b1;
        deliv.delete();
        push_a({3{32'h0000_0030}}, {3{32'h0000_0010}}, {3{32'h0000_0020}});
        push_b({3{32'h0000_0300}}, {3{32'h0000_0100}}, {3{32'h0000_0200}});
        wait_drain("post_reset", 50);
        order = '0;
        for (int i = 0; i < 2; i++) if (i < deliv.size()) order[i] = deliv[i];
        chk("post_reset_order", 128'({deliv.size() == 2, order[1:0]}), 128'(3'b110));
        chk("final_inflight", 128'(inflight), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
